seq_restoring_divider: RTL and testbench

//   Iterative restoring divider: unsigned DW-bit dividend / VW-bit divisor -> DW-bit quotient + VW-bit remainder.

---
 rtl/div_pkg.sv | 18 +
 rtl/seq_restoring_divider_if.sv | 30 +++
 rtl/divider_check_mac.sv | 29 ++
 rtl/seq_restoring_divider.sv | 132 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

   localparam int DW_DEF = 8;   // dividend / quotient width
   localparam int VW_DEF = 4;   // divisor / remainder width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width able to hold the value dw (the number of quotient bits).
   function automatic int cnt_width(input int dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand / result handshake bundle of the sequential restoring divider.
// master = producer/consumer side, slave = divider side.
interface seq_restoring_divider_if
   import div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero
   );

endinterface

// File: rtl/divider_check_mac.sv
// Result self-check: flags quotient*divisor + remainder != dividend.
// Only present when DIVIDER_SELFCHECK_EN is defined.
`ifdef DIVIDER_SELFCHECK_EN
module divider_check_mac
   import div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic [DW-1:0] quotient,
   input  logic [VW-1:0] divisor,
   input  logic [VW-1:0] remainder,
   input  logic [DW-1:0] dividend,
   input  logic          active,
   output logic          chk_err
);

   localparam int PW = DW + VW;

   logic [PW-1:0] recon;

   // Rebuild the dividend from the result and compare against the latched one.
   always_comb begin
      recon   = PW'(quotient) * PW'(divisor) + PW'(remainder);
      chk_err = active && (recon != PW'(dividend));
   end

endmodule
`endif

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per enabled clock,
// valid/ready handshake on operands and result.
// Optional DIVIDER_SELFCHECK_EN adds the chk_err output driven by
// divider_check_mac.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
`ifdef DIVIDER_SELFCHECK_EN
   output logic chk_err,
`endif
   seq_restoring_divider_if.slave bus
);

   localparam int CW = cnt_width(DW);

   state_t        state_q, state_d;
   logic [VW:0]   r_q, r_d;        // partial remainder, one spare bit
   logic [DW-1:0] q_q, q_d;        // dividend shifts out, quotient shifts in
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VW-1:0] dsr_q, dsr_d;    // latched divisor
   logic          dz_q, dz_d;

   logic [VW+1:0] trial;
   logic [VW:0]   diff;
   logic          fits;
   logic          done;

   // Trial subtraction: shift in the next dividend bit and test against divisor.
   always_comb begin
      trial = {r_q, q_q[DW-1]};
      fits  = (trial >= {2'b00, dsr_q});
      diff  = trial[VW:0] - {1'b0, dsr_q};
   end

   // Next-state logic for FSM and datapath registers; ena=0 holds everything.
   always_comb begin
      // NOTE: every output gets its hold value first so no path infers a latch.
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      dsr_d   = dsr_q;
      dz_d    = dz_q;
      if (ena) begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  dsr_d = bus.divisor;
                  r_d   = '0;
                  if (bus.divisor == '0) begin
                     state_d = DONE;
                     q_d     = '1;
                     dz_d    = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     state_d = CALC;
                     q_d     = bus.dividend;
                     dz_d    = 1'b0;
                     cnt_d   = CW'(DW);
                  end
               end
            end
            CALC: begin
               r_d   = fits ? diff : trial[VW:0];
               q_d   = {q_q[DW-2:0], fits};
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
               if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (!rst_n) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         dsr_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         dsr_q   <= dsr_d;
         dz_q    <= dz_d;
      end
   end

   assign done          = (state_q == DONE);
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = done;
   assign bus.quotient  = done ? q_q : '0;
   assign bus.remainder = done ? r_q[VW-1:0] : '0;
   assign bus.div_zero  = done & dz_q;

`ifdef DIVIDER_SELFCHECK_EN
   logic [DW-1:0] dvd_q;

   // Keep the accepted dividend for the reconstruction check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   dvd_q <= '0;
      else if (ena && bus.in_ready && bus.in_valid) dvd_q <= bus.dividend;
   end

   divider_check_mac #(
      .DW (DW),
      .VW (VW)
   ) u_check_mac (
      .quotient  (q_q),
      .divisor   (dsr_q),
      .remainder (r_q[VW-1:0]),
      .dividend  (dvd_q),
      .active    (done && !dz_q),
      .chk_err   (chk_err)
   );
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed corner cases,
// backpressure, clock-enable toggling, mid-operation reset and random
// operands against an arithmetic reference model.
module tb_seq_restoring_divider;
   import div_pkg::*;

   localparam int DW = DW_DEF;
   localparam int VW = VW_DEF;

   logic clk = 1'b0;
   logic rst_n;
   logic ena;
   int   checks = 0;
   int   errors = 0;
   bit   toggle_en = 1'b0;

   seq_restoring_divider_if #(.DW(DW), .VW(VW)) bus ();

`ifdef DIVIDER_SELFCHECK_EN
   logic chk_err;
`endif

   seq_restoring_divider #(
      .DW (DW),
      .VW (VW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
`ifdef DIVIDER_SELFCHECK_EN
      .chk_err (chk_err),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock edge; reports whether ena was high at that edge.
   task automatic step(output bit was_en);
      was_en = ena;
      @(posedge clk);
      #1;
      if (toggle_en) ena = ~ena;
   endtask

   // Full transaction: offer operands, wait for result, check it, hold it
   // for 'hold' cycles under backpressure, then retire it.
   task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b, input int hold);
      int exp_q, exp_r, exp_dz, n, guard;
      bit en;
      if (b == '0) begin
         exp_q  = (1 << DW) - 1;
         exp_r  = 0;
         exp_dz = 1;
      end else begin
         exp_q  = int'(a) / int'(b);
         exp_r  = int'(a) % int'(b);
         exp_dz = 0;
      end

      check("in_ready_idle", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      guard = 0;
      do begin
         step(en);
         guard++;
      end while (!en && guard < 10);
      bus.in_valid = 1'b0;
      // Operand changes after acceptance must have no effect.
      bus.dividend = DW'($urandom);
      bus.divisor  = VW'($urandom);

      n = 0;
      guard = 0;
      while (!bus.out_valid && guard < 100) begin
         step(en);
         guard++;
         if (en) n++;
      end
      check("result_timeout", guard < 100, 1);
      check("latency", n, (b == '0) ? 0 : DW);
      check("out_valid", bus.out_valid, 1);
      check("in_ready_busy", bus.in_ready, 0);
      check("quotient", bus.quotient, exp_q);
      check("remainder", bus.remainder, exp_r);
      check("div_zero", bus.div_zero, exp_dz);
`ifdef DIVIDER_SELFCHECK_EN
      check("chk_err", chk_err, 0);
`endif

      bus.out_ready = 1'b0;
      for (int k = 0; k < hold; k++) begin
         step(en);
         check("hold_out_valid", bus.out_valid, 1);
         check("hold_in_ready", bus.in_ready, 0);
         check("hold_quotient", bus.quotient, exp_q);
         check("hold_remainder", bus.remainder, exp_r);
      end

      bus.out_ready = 1'b1;
      guard = 0;
      do begin
         step(en);
         guard++;
      end while (!en && guard < 10);
      bus.out_ready = 1'b0;
      check("retire_out_valid", bus.out_valid, 0);
      check("retire_in_ready", bus.in_ready, 1);
   endtask

   initial begin
      bit en;
      logic [DW-1:0] ra;
      logic [VW-1:0] rb;

      rst_n         = 1'b0;
      ena           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      #12;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_div_zero", bus.div_zero, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed values and boundaries.
      run_div(8'd200, 4'd7, 0);
      run_div(8'd225, 4'd15, 0);
      run_div(8'd255, 4'd1, 0);
      run_div(8'd5, 4'd9, 0);
      run_div(8'd255, 4'd15, 0);
      run_div(8'd0, 4'd5, 0);
      run_div(8'd77, 4'd0, 0);

      // Backpressure on the result.
      run_div(8'd200, 4'd7, 5);

      // Clock enable toggled every cycle.
      toggle_en = 1'b1;
      run_div(8'd200, 4'd7, 2);
      toggle_en = 1'b0;
      ena = 1'b1;

      // Reset in the middle of a calculation.
      bus.in_valid = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 4'd7;
      step(en);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) step(en);
      check("mid_calc_busy", bus.in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_quotient", bus.quotient, 0);
      check("midrst_remainder", bus.remainder, 0);
      check("midrst_div_zero", bus.div_zero, 0);
      rst_n = 1'b1;
      run_div(8'd100, 4'd3, 0);

      // Random operands, half with a toggling enable.
      for (int i = 0; i < 40; i++) begin
         ra = DW'($urandom_range(0, 255));
         rb = VW'($urandom_range(0, 15));
         toggle_en = i[0];
         run_div(ra, rb, int'($urandom_range(0, 2)));
         toggle_en = 1'b0;
         ena = 1'b1;
      end

`ifdef DIVIDER_SELFCHECK_EN
      // Exhaustive sweep with nonzero divisors.
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            run_div(DW'(a), VW'(b), 0);
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
